// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-ported memory between the fetch port (i_*) and the
//   memory-stage data port (d_*). One transaction is outstanding at a time.
//   Data wins ties until it has been granted MAX_STREAK times in a row while
//   fetch was waiting; then fetch gets the next grant.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no transaction; arbitrate between i_req and d_req
//   BUSY_I | fetch transaction on mem_*, waiting for mem_ack
//   BUSY_D | data transaction on mem_*, waiting for mem_ack
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   i_req/i_addr          fetch request and address (held until i_done)
//   i_done/i_rdata        fetch completion and instruction
//   d_req/d_we/d_type     data request, store flag, access type
//   d_addr/d_wdata        data address and store data
//   d_done/d_rdata        data completion and load data
//   mem_req..mem_wdata    registered memory request (held until mem_ack)
//   mem_ack/mem_rdata     memory completion and read data
//   stall_f/stall_m       fetch / memory-stage stalls for the hazard unit
//   conflicts             saturating count of IDLE cycles with both requests

module unified_mem_arbiter #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned ILEN       = 32,
  parameter int unsigned MTW        = 3,
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned CNTW       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_done,
  output logic [ILEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [MTW-1:0]  d_type,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_done,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [MTW-1:0]  mem_type,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            stall_f,
  output logic            stall_m,
  output logic [CNTW-1:0] conflicts
);

  // Fetches are always word-unsigned (funct3-style encoding 3'b110).
  localparam logic [MTW-1:0]  TYPE_WORDU = MTW'(3'b110);
  localparam logic [3:0]      STREAK_MAX = 4'(MAX_STREAK);
  localparam logic [CNTW-1:0] CONF_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       grant_i;
  logic       grant_d;
  logic [3:0] streak;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A pending fetch only beats a pending data access once data has used up
  // its streak allowance.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && (!d_req || streak == STREAK_MAX)) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end else if (d_req) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // mem_* are loaded only on a grant, so they stay frozen for the whole
  // transaction whatever the requesters do.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_type  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_i) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_type  <= TYPE_WORDU;
      mem_addr  <= i_addr;
      mem_wdata <= '0;
    end else if (grant_d) begin
      mem_req   <= 1'b1;
      mem_we    <= d_we;
      mem_type  <= d_type;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
    end else if (state != IDLE && mem_ack) begin
      mem_req   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak <= '0;
    end else if (grant_d) begin
      if (!i_req) begin
        streak <= '0;
      end else if (streak != STREAK_MAX) begin
        streak <= streak + 4'd1;
      end
    end else if (grant_i) begin
      streak <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflicts <= '0;
    end else if (state == IDLE && i_req && d_req && conflicts != CONF_MAX) begin
      conflicts <= conflicts + CNTW'(1);
    end
  end

  // Done is gated by the live request so a flushed requester gets no done,
  // while the memory side still completes normally.
  assign i_done  = (state == BUSY_I) & mem_ack & i_req;
  assign d_done  = (state == BUSY_D) & mem_ack & d_req;
  assign i_rdata = mem_rdata[ILEN-1:0];
  assign d_rdata = mem_rdata;
  assign stall_f = i_req & ~i_done;
  assign stall_m = d_req & ~d_done;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

  localparam int CNTW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [63:0] i_addr = '0;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_type = '0;
  logic [63:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        d_done;
  logic [63:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_type;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        stall_f;
  logic        stall_m;
  logic [CNTW-1:0] conflicts;

  unified_mem_arbiter #(.XLEN(64), .ILEN(32), .MTW(3), .MAX_STREAK(4), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_type(d_type), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_type(mem_type), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m), .conflicts(conflicts)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rdata_of(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[63:32]};
  endfunction

  // memory responder configuration (written by the stimulus only)
  int          fixed_lat = 0;
  bit          rand_lat = 1'b0;
  bit          use_ovr = 1'b0;
  logic [63:0] ovr_data = '0;
  bit          resp_en = 1'b1;
  int          manual_ack_cyc = -1;

  // reference model state (written by the model process only)
  int          cyc = 0;
  bit          m_busy = 1'b0;
  bit          m_owner_i = 1'b0;
  int          m_waited = 0;
  int          m_conf = 0;
  logic [63:0] m_addr = '0;
  logic        m_we = 1'b0;
  logic [2:0]  m_type = '0;
  logic [63:0] m_wdata = '0;

  // Reference model: one transaction at a time; a free memory is offered to
  // data first unless fetch has already watched 4 data grants in a row.
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_busy   = 1'b0;
      m_waited = 0;
      m_conf   = 0;
    end else if (!m_busy) begin
      if (i_req && d_req && m_conf < (1 << CNTW) - 1) m_conf++;
      if (i_req && (!d_req || m_waited >= 4)) begin
        m_busy = 1'b1; m_owner_i = 1'b1; m_waited = 0;
        m_addr = i_addr; m_we = 1'b0; m_type = 3'b110; m_wdata = '0;
      end else if (d_req) begin
        m_busy = 1'b1; m_owner_i = 1'b0;
        m_waited = i_req ? ((m_waited < 4) ? m_waited + 1 : 4) : 0;
        m_addr = d_addr; m_we = d_we; m_type = d_type; m_wdata = d_wdata;
      end
    end else if (mem_ack) begin
      m_busy = 1'b0;
    end
  end

  // memory responder: acks after a latency, one-cycle ack pulse
  int r_cnt = 0;
  int r_lat = 0;
  bit r_active = 1'b0;
  always @(posedge clk) begin
    #1;
    if (mem_ack) begin
      mem_ack  = 1'b0;
      r_active = 1'b0;
    end else if (cyc == manual_ack_cyc) begin
      mem_ack   = 1'b1;
      mem_rdata = 64'h0BAD;
    end else if (!mem_req || !resp_en) begin
      r_active = 1'b0;
    end else begin
      if (!r_active) begin
        r_active = 1'b1;
        r_cnt    = 0;
        r_lat    = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
      end
      if (r_cnt >= r_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = use_ovr ? ovr_data : rdata_of(mem_addr);
      end else begin
        r_cnt++;
      end
    end
  end

  int  n_assert = 0;
  int  n_fail = 0;
  int  i_done_cnt = 0;
  int  d_done_cnt = 0;
  bit  prev_req = 1'b0;
  byte unsigned grant_log[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mon_check();
    logic exp_busy, exp_id, exp_dd;
    logic [63:0] exp_rd;
    exp_busy = reset && m_busy;
    exp_id   = exp_busy && m_owner_i && mem_ack && i_req;
    exp_dd   = exp_busy && !m_owner_i && mem_ack && d_req;
    exp_rd   = use_ovr ? ovr_data : rdata_of(m_addr);
    chk("mem_req", 64'(mem_req), 64'(exp_busy));
    if (exp_busy) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", 64'(mem_we), 64'(m_we));
      chk("mem_type", 64'(mem_type), 64'(m_type));
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("i_done", 64'(i_done), 64'(exp_id));
    chk("d_done", 64'(d_done), 64'(exp_dd));
    chk("stall_f", 64'(stall_f), 64'(i_req && !exp_id));
    chk("stall_m", 64'(stall_m), 64'(d_req && !exp_dd));
    chk("conflicts", 64'(conflicts), reset ? 64'(m_conf) : 64'd0);
    if (exp_id) chk("i_rdata", 64'(i_rdata), 64'(exp_rd[31:0]));
    if (exp_dd && !m_we) chk("d_rdata", d_rdata, exp_rd);
    if (mem_req && !prev_req) grant_log.push_back((!mem_we && mem_type == 3'b110) ? 8'h49 : 8'h44);
    prev_req = mem_req;
    if (i_done) i_done_cnt++;
    if (d_done) d_done_cnt++;
  endtask

  task automatic half_neg();
    @(negedge clk);
    mon_check();
  endtask

  task automatic half_pos();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n0, nI, ack_cyc, i_used, d_used;

    // reset with a fetch already pending
    reset = 1'b0; i_req = 1'b1; i_addr = 64'h1000;
    fixed_lat = 2; use_ovr = 1'b1; ovr_data = 64'h0050_0093;
    half_neg();
    chk("rst_stall_f", 64'(stall_f), 64'd1);
    chk("rst_stall_m", 64'(stall_m), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_conflicts", 64'(conflicts), 64'd0);
    half_pos();
    half_neg(); half_pos();
    reset = 1'b1;

    // single fetch, ack 2 cycles after mem_req
    for (int k = 0; k < 20; k++) begin
      half_neg();
      if (i_done === 1'b1) break;
      chk("t1_stall_f_wait", 64'(stall_f), 64'd1);
      half_pos();
    end
    chk("t1_i_done", 64'(i_done), 64'd1);
    chk("t1_i_rdata", 64'(i_rdata), 64'h0050_0093);
    chk("t1_mem_addr", mem_addr, 64'h1000);
    chk("t1_mem_we", 64'(mem_we), 64'd0);
    chk("t1_stall_f_done", 64'(stall_f), 64'd0);
    half_pos();
    i_req = 1'b0;
    half_neg(); half_pos();
    half_neg();
    chk("t1_done_once", 64'(i_done_cnt), 64'd1);
    half_pos();

    // load while fetch idle
    ovr_data = 64'hFFFF_FFFF_FFFF_FF80; fixed_lat = 1;
    n0 = grant_log.size();
    d_req = 1'b1; d_we = 1'b0; d_type = 3'b011; d_addr = 64'h4010;
    for (int k = 0; k < 20; k++) begin
      half_neg();
      if (d_done === 1'b1) break;
      chk("t3_stall_m_wait", 64'(stall_m), 64'd1);
      half_pos();
    end
    chk("t3_d_done", 64'(d_done), 64'd1);
    chk("t3_d_rdata", d_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    half_pos();
    d_req = 1'b0;
    half_neg();
    chk("t3_stall_m_after", 64'(stall_m), 64'd0);
    chk("t3_one_grant", 64'(grant_log.size()), 64'(n0 + 1));
    chk("t3_grant_is_d", 64'(grant_log[grant_log.size() - 1]), 64'h44);
    half_pos();

    // fetch withdrawn mid-transaction, data pending behind it
    use_ovr = 1'b0; fixed_lat = 4;
    nI = i_done_cnt;
    i_req = 1'b1; i_addr = 64'h5000;
    for (int k = 0; k < 10; k++) begin
      half_neg();
      if (mem_req === 1'b1) break;
      half_pos();
    end
    chk("t4_fetch_granted", 64'(mem_req), 64'd1);
    half_pos();
    i_req = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_type = 3'b011; d_addr = 64'h6000; d_wdata = 64'h1122_3344_5566_7788;
    for (int k = 0; k < 10; k++) begin
      half_neg();
      if (mem_ack === 1'b1) break;
      half_pos();
    end
    chk("t4_ack_seen", 64'(mem_ack), 64'd1);
    chk("t4_no_i_done", 64'(i_done), 64'd0);
    ack_cyc = cyc;
    half_pos();
    for (int k = 0; k < 10; k++) begin
      half_neg();
      if (mem_req === 1'b1 && mem_we === 1'b1) break;
      half_pos();
    end
    chk("t4_d_granted", 64'(mem_req && mem_we), 64'd1);
    chk("t4_d_grant_cycle", 64'(cyc - ack_cyc), 64'd2);
    chk("t4_i_done_count", 64'(i_done_cnt), 64'(nI));
    half_pos();
    for (int k = 0; k < 10; k++) begin
      half_neg();
      if (d_done === 1'b1) break;
      half_pos();
    end
    chk("t4_d_done", 64'(d_done), 64'd1);
    half_pos();
    d_req = 1'b0; d_we = 1'b0;
    half_neg(); half_pos();

    // both requesting continuously: D,D,D,D,I,... and conflicts saturating
    fixed_lat = 0;
    half_neg();
    chk("t5_conf_start", 64'(conflicts), 64'd0);
    half_pos();
    n0 = grant_log.size();
    i_req = 1'b1; i_addr = 64'h3000;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h2008; d_wdata = 64'hDEAD_BEEF; d_type = 3'b011;
    for (int k = 0; k < 50; k++) begin
      half_neg(); half_pos();
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      half_neg(); half_pos();
    end
    half_neg();
    chk("t5_conf_saturated", 64'(conflicts), 64'hF);
    chk("t5_grant_count", 64'(grant_log.size() >= n0 + 10), 64'd1);
    for (int g = 0; g < 10; g++) begin
      chk("t5_grant_order", 64'(grant_log[n0 + g]), (g % 5 == 4) ? 64'h49 : 64'h44);
    end
    half_pos();

    // asynchronous reset during BUSY_D, then a stray ack
    resp_en = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_type = 3'b011; d_addr = 64'h7000;
    for (int k = 0; k < 10; k++) begin
      half_neg();
      if (mem_req === 1'b1) break;
      half_pos();
    end
    chk("t6_busy_d", 64'(mem_req), 64'd1);
    half_pos();
    reset = 1'b0; d_req = 1'b0;
    #1;
    chk("t6_mem_req_async", 64'(mem_req), 64'd0);
    chk("t6_mem_addr_async", mem_addr, 64'd0);
    chk("t6_conf_async", 64'(conflicts), 64'd0);
    chk("t6_d_done_async", 64'(d_done), 64'd0);
    half_neg(); half_pos();
    half_neg(); half_pos();
    reset = 1'b1;
    manual_ack_cyc = cyc + 1;
    half_neg(); half_pos();
    half_neg();
    chk("t6_no_d_done", 64'(d_done), 64'd0);
    chk("t6_no_i_done", 64'(i_done), 64'd0);
    half_pos();
    half_neg();
    chk("t6_stays_idle", 64'(mem_req), 64'd0);
    half_pos();
    manual_ack_cyc = -1; resp_en = 1'b1;

    // streak restarts from zero: four data grants before fetch again
    n0 = grant_log.size();
    i_req = 1'b1; i_addr = 64'h3000;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h2008; d_wdata = 64'hDEAD_BEEF; d_type = 3'b011;
    for (int k = 0; k < 12; k++) begin
      half_neg(); half_pos();
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    half_neg(); half_pos();
    half_neg();
    for (int g = 0; g < 5; g++) begin
      chk("t6_grant_order", 64'(grant_log[n0 + g]), (g == 4) ? 64'h49 : 64'h44);
    end
    half_pos();

    // randomized traffic against the model
    rand_lat = 1'b1;
    i_used = i_done_cnt; d_used = d_done_cnt;
    for (int t = 0; t < 800; t++) begin
      half_neg(); half_pos();
      if (i_req) begin
        if (i_done_cnt != i_used) begin
          i_used = i_done_cnt;
          if ($urandom_range(0, 1) == 1) i_addr = {$urandom, $urandom};
          else i_req = 1'b0;
        end else if ($urandom_range(0, 39) == 0) begin
          i_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        i_req = 1'b1; i_addr = {$urandom, $urandom};
      end
      if (d_req) begin
        if (d_done_cnt != d_used) begin
          d_used = d_done_cnt;
          if ($urandom_range(0, 1) == 1) begin
            d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
            d_we = 1'($urandom_range(0, 1)); d_type = 3'($urandom_range(0, 7));
          end else begin
            d_req = 1'b0;
          end
        end else if ($urandom_range(0, 39) == 0) begin
          d_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
        d_we = 1'($urandom_range(0, 1)); d_type = 3'($urandom_range(0, 7));
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      half_neg(); half_pos();
    end
    half_neg();
    chk("end_idle", 64'(mem_req), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory between the pipelined core's fetch port (PC) and its memory-stage data port (load/store address, write data, access type).
- One transaction outstanding at a time.
- Data accesses have priority, with a bounded-streak rule so fetch is never starved.
- Produces per-port stall signals the hazard logic uses to freeze the fetch stage or the memory stage.

Parameters:
- XLEN, 64, address and data width (matches the core data bus)
- ILEN, 32, instruction width returned to fetch
- MTW, 3, memory access type width (byte/half/word/double, signed/unsigned)
- MAX_STREAK, 4, consecutive data grants allowed while fetch waits; range 1..15
- CNTW, 32, conflict counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- i_req  in  1  fetch request; held until i_done
- i_addr  in  XLEN  fetch address
- i_done  out  1  fetch complete; i_rdata valid this cycle
- i_rdata  out  ILEN  fetched instruction (mem_rdata[ILEN-1:0])
- d_req  in  1  data request; held until d_done
- d_we  in  1  1 = store
- d_type  in  MTW  access type
- d_addr  in  XLEN  data address
- d_wdata  in  XLEN  store data
- d_done  out  1  data access complete; d_rdata valid this cycle for loads
- d_rdata  out  XLEN  load data
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write enable
- mem_type  out  MTW  memory access type
- mem_addr  out  XLEN  memory address
- mem_wdata  out  XLEN  memory write data
- mem_ack  in  1  memory completes the current request; mem_rdata valid this cycle
- mem_rdata  in  XLEN  memory read data
- stall_f  out  1  i_req & ~i_done
- stall_m  out  1  d_req & ~d_done
- conflicts  out  CNTW  saturating count of IDLE cycles with both requests high

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE with no requests: stay in IDLE.
- IDLE with d_req only: go to BUSY_D.
- IDLE with i_req only: go to BUSY_I.
- IDLE with both requests: go to BUSY_I if streak == MAX_STREAK, else BUSY_D.
- On entering BUSY_x: register the winning port's addr/we/type/wdata into mem_* and assert mem_req (registered).
  - For fetch: mem_we = 0, mem_type = word-unsigned encoding, mem_wdata = 0.
- BUSY_x with mem_ack: return to IDLE; mem_req deasserts in the next cycle.
- Completion signals are combinational:
  - i_done = (state == BUSY_I) & mem_ack & i_req.
  - d_done = (state == BUSY_D) & mem_ack & d_req.
  - rdata outputs are passthrough of mem_rdata; they are don't-care when the corresponding done is 0.
- Latency: request seen in IDLE at cycle N → mem_req at N+1 → earliest done at N+1. Back-to-back accesses therefore take at least 2 cycles each (one IDLE arbitration cycle per access).
- Streak counter (4 bits):
  - on a data grant with i_req high: increment, saturating at MAX_STREAK;
  - on a data grant with i_req low: clear;
  - on a fetch grant: clear.
- Requester contract:
  - req, addr and data are stable from assertion until done.
  - req deasserts in the cycle after done, or is re-asserted for a new access. The arbiter only samples req in IDLE, so the just-served req high in the done cycle is never double-granted.
- Request withdrawn while BUSY_x (pipeline flush): the memory transaction still completes (no abort on the memory side), done is suppressed, and the FSM returns to IDLE on mem_ack.
- mem_* outputs hold their values while mem_req = 1, regardless of input changes.
- conflicts increments in IDLE when i_req & d_req; it saturates at all-ones and never wraps.
- Reset (asynchronous, at any time, including mid-transaction):
  - state = IDLE; mem_req = 0; mem_we = 0; mem_type, mem_addr, mem_wdata = 0; streak = 0; conflicts = 0.
  - The in-flight memory access is abandoned; any mem_ack arriving in IDLE is ignored.
- Reset values of combinational outputs (i_done, d_done, stall_f, stall_m, i_rdata, d_rdata) follow their equations with state = IDLE: i_done = d_done = 0; stall_f = i_req; stall_m = d_req.

Test Plan:
- Single fetch, i_addr=0x1000, mem_ack 2 cycles after mem_req with rdata=0x00500093 → mem_addr=0x1000, mem_we=0, i_done pulses once with i_rdata=0x00500093, stall_f high until that cycle, then IDLE.
- Simultaneous i_req and d_req (store, addr 0x2008, wdata 0xDEADBEEF, d_type=3'b011) with both re-requesting continuously, MAX_STREAK=4, mem_ack immediate → grant order D,D,D,D,I,D,…; conflicts increments each IDLE cycle with both high.
- Load with d_rdata=0xFFFFFFFFFFFFFF80 while fetch idle → streak stays 0, d_done in the ack cycle, stall_m=0 afterwards, no fetch grant.
- Fetch withdrawn mid-transaction (i_req drops one cycle after mem_req, ack 3 cycles later) → i_done never asserts, FSM returns to IDLE on ack, and a pending d_req is granted in the next IDLE cycle.
- Reset driven to 0 during BUSY_D, then mem_ack arrives → mem_req=0 immediately (asynchronously), no d_done, streak=0, conflicts=0.
- conflicts forced near saturation (CNTW=4, 20 conflict cycles) → value holds at 0xF, does not wrap.
